// File: rtl/div_iter.sv
// Radix-2 restoring iterative divider, signed/unsigned quotient or remainder.
// Optional macro DIV_EARLY_OUT_EN: finish divide-by-zero, signed overflow and |a|<|b| in one cycle.
//
// state | meaning
// IDLE  | waiting for start
// BUSY  | one quotient bit per edge, WIDTH edges
// FIX   | apply signs / special-case overrides, load result
// DONE  | done=1 for one cycle, may accept a new start
module div_iter #(
    parameter int WIDTH = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic [1:0]       div_type,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] quo, rem, dvs_mag;
    logic             neg_a, neg_b, rem_sel, div_zero;

    logic             accept, early, in_signed, a_neg_in, b_neg_in, sp_zero;
    logic [WIDTH-1:0] a_mag_in, b_mag_in, early_val, q_fix, r_fix;
    logic [WIDTH:0]   trial;

    assign in_signed = ~div_type[0];
    assign a_neg_in  = in_signed & dividend[WIDTH-1];
    assign b_neg_in  = in_signed & divisor[WIDTH-1];
    assign a_mag_in  = a_neg_in ? -dividend : dividend;
    assign b_mag_in  = b_neg_in ? -divisor : divisor;
    assign sp_zero   = (divisor == '0);
    assign accept    = start & ((state == S_IDLE) | (state == S_DONE));

`ifdef DIV_EARLY_OUT_EN
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    logic sp_ovf, sp_small;
    assign sp_ovf   = in_signed & (dividend == MIN_VAL) & (divisor == '1);
    assign sp_small = (a_mag_in < b_mag_in);
    assign early    = sp_zero | sp_ovf | sp_small;

    always_comb begin
        early_val = '0;
        if (sp_zero)
            early_val = div_type[1] ? dividend : '1;
        else if (sp_ovf)
            early_val = div_type[1] ? '0 : dividend;
        else
            early_val = div_type[1] ? dividend : '0;
    end
`else
    assign early     = 1'b0;
    assign early_val = '0;
`endif

    // Partial remainder never exceeds the divisor, so WIDTH+1 bits hold the trial difference.
    assign trial = {rem, quo[WIDTH-1]} - {1'b0, dvs_mag};

    assign q_fix = div_zero ? '1 : ((neg_a ^ neg_b) ? -quo : quo);
    assign r_fix = neg_a ? -rem : rem;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: if (start) state_nxt = early ? S_DONE : S_BUSY;
            S_BUSY: begin
                busy = 1'b1;
                if (count == CW'(1)) state_nxt = S_FIX;
            end
            S_FIX: begin
                busy      = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start)
                    state_nxt = early ? S_DONE : S_BUSY;
                else
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            quo      <= '0;
            rem      <= '0;
            dvs_mag  <= '0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            rem_sel  <= 1'b0;
            div_zero <= 1'b0;
            result   <= '0;
        end else if (accept) begin
            quo      <= a_mag_in;
            rem      <= '0;
            dvs_mag  <= b_mag_in;
            neg_a    <= a_neg_in;
            neg_b    <= b_neg_in;
            rem_sel  <= div_type[1];
            div_zero <= sp_zero;
            count    <= early ? '0 : CW'(WIDTH);
            if (early) result <= early_val;
        end else if (state == S_BUSY) begin
            if (!trial[WIDTH]) begin
                rem <= trial[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
                rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
                quo <= {quo[WIDTH-2:0], 1'b0};
            end
            count <= count - CW'(1);
        end else if (state == S_FIX) begin
            result <= rem_sel ? r_fix : q_fix;
        end
    end
endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: vector table through a scoreboard queue,
// plus hand sequences for ignored start, back-to-back start and mid-op reset.
`timescale 1ns/1ps
module tb_div_iter;
    localparam int W = 64;
    localparam logic [W-1:0] MIN = 64'h8000_0000_0000_0000;
    localparam logic [W-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [1:0] T_DIV = 2'b00, T_DIVU = 2'b01, T_REM = 2'b10, T_REMU = 2'b11;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic [1:0]   div_type = '0;
    logic [W-1:0] result;
    logic         busy, done;

    always #5 clock = ~clock;

    div_iter #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .start(start), .dividend(dividend),
        .divisor(divisor), .div_type(div_type), .result(result),
        .busy(busy), .done(done)
    );

    typedef struct {
        logic [1:0]   t;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] e;
    } vec_t;

    vec_t         vecs[$];
    logic [W-1:0] exp_q[$];
    int           n_vec = 0;
    int           n_bad = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [1:0] t, input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0) return t[1] ? a : ONES;
        if (!t[0]) begin
            if (a == MIN && b == ONES) return t[1] ? '0 : a;
            return t[1] ? W'($signed(a) % $signed(b)) : W'($signed(a) / $signed(b));
        end
        return t[1] ? a % b : a / b;
    endfunction

    function automatic logic [W-1:0] mag(input logic [1:0] t, input logic [W-1:0] x);
        return (!t[0] && x[W-1]) ? -x : x;
    endfunction

    function automatic bit is_special(input logic [1:0] t, input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == '0) || (!t[0] && a == MIN && b == ONES) || (mag(t, a) < mag(t, b));
    endfunction

    function automatic int exp_lat(input logic [1:0] t, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef DIV_EARLY_OUT_EN
        if (is_special(t, a, b)) return 0;
`endif
        return W + 1;
    endfunction

    function automatic void add(input logic [1:0] t, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] e);
        vec_t v;
        v.t = t; v.a = a; v.b = b; v.e = e;
        vecs.push_back(v);
    endfunction

    // Called at a negedge; the following posedge samples start.
    task automatic start_op(input logic [1:0] t, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] e);
        div_type = t; dividend = a; divisor = b; start = 1'b1;
        exp_q.push_back(e);
        @(negedge clock);
        start = 1'b0;
    endtask

    // Returns at the negedge where done is first seen high.
    task automatic wait_done(input int lat0, input int elat, input int ebusy, input string name);
        int lat = lat0;
        int bc = 0;
        logic [W-1:0] e;
        while (done !== 1'b1 && lat < 300) begin
            if (busy === 1'b1) bc++;
            @(negedge clock);
            lat++;
        end
        check($sformatf("%s latency", name), W'(lat), W'(elat));
        check($sformatf("%s busy cycles", name), W'(bc), W'(ebusy));
        if (exp_q.size() == 0) begin
            check($sformatf("%s scoreboard empty", name), W'(1), W'(0));
        end else begin
            e = exp_q.pop_front();
            check($sformatf("%s result", name), result, e);
        end
    endtask

    task automatic run_op(input logic [1:0] t, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] e, input string name);
        int el = exp_lat(t, a, b);
        start_op(t, a, b, e);
        wait_done(0, el, (el == 0) ? 0 : W + 1, name);
        @(negedge clock);
        check($sformatf("%s done width", name), W'(done), W'(0));
        @(negedge clock);
        check($sformatf("%s result hold", name), result, e);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcount;
        logic [W-1:0] ra, rb;
        logic [1:0] rt;

        add(T_DIV,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        add(T_REM,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES);
        add(T_DIVU, 64'd100, 64'd7, 64'd14);
        add(T_REMU, 64'd100, 64'd7, 64'd2);
        add(T_DIV,  64'd5, 64'd0, ONES);
        add(T_REM,  64'd5, 64'd0, 64'd5);
        add(T_DIV,  MIN, ONES, MIN);
        add(T_REM,  MIN, ONES, 64'd0);
        add(T_DIVU, 64'd5, 64'd0, ONES);
        add(T_REMU, 64'd5, 64'd0, 64'd5);
        add(T_DIV,  64'hFFFF_FFFF_FFFF_FFFB, 64'd0, ONES);
        add(T_REM,  64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB);
        add(T_DIV,  64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD);
        add(T_REM,  64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1);
        add(T_DIV,  64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 64'd14);
        add(T_REM,  64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE);
        add(T_DIVU, ONES, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF);
        add(T_REMU, ONES, 64'd2, 64'd1);
        add(T_DIVU, 64'd3, 64'd10, 64'd0);
        add(T_REMU, 64'd3, 64'd10, 64'd3);
        add(T_DIVU, MIN, ONES, 64'd0);
        add(T_REMU, MIN, ONES, MIN);
        add(T_DIV,  MIN, 64'd1, MIN);
        add(T_REM,  64'hFFFF_FFFF_FFFF_FFFD, 64'd10, 64'hFFFF_FFFF_FFFF_FFFD);
        for (int i = 0; i < 8; i++) begin
            rt = 2'($urandom_range(0, 3));
            ra = {$urandom, $urandom};
            rb = (i < 4) ? W'($urandom_range(1, 1000)) : {1'b0, 31'($urandom), $urandom};
            add(rt, ra, rb, model(rt, ra, rb));
        end

        #2;
        check("reset result", result, '0);
        check("reset busy", W'(busy), W'(0));
        check("reset done", W'(done), W'(0));
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        foreach (vecs[i])
            run_op(vecs[i].t, vecs[i].a, vecs[i].b, vecs[i].e, $sformatf("vec%0d", i));

        // start while busy is ignored; start in the DONE cycle is accepted
        start_op(T_DIVU, 64'd100, 64'd7, 64'd14);
        repeat (9) @(negedge clock);
        div_type = T_DIVU; dividend = 64'd9; divisor = 64'd3; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done(10, W + 1, W + 1 - 10, "ignored start");
        start_op(T_DIVU, 64'd9, 64'd3, 64'd3);
        wait_done(0, W + 1, W + 1, "back to back");
        @(negedge clock);
        check("back to back done width", W'(done), W'(0));

        // reset in the middle of an operation
        start_op(T_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        repeat (29) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("midreset busy", W'(busy), W'(0));
        check("midreset done", W'(done), W'(0));
        check("midreset result", result, '0);
        exp_q.delete();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        dcount = 0;
        repeat (100) begin
            @(negedge clock);
            if (done === 1'b1) dcount++;
        end
        check("no done after reset", W'(dcount), W'(0));
        run_op(T_DIVU, 64'd6, 64'd3, 64'd2, "after reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/div_iter.md
DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 Parameter WIDTH, default 64: operand and result width in bits; all widths below are in terms of WIDTH.
REQ-002 Port clock, input, 1: single clock; all state changes on the rising edge.
REQ-003 Port reset, input, 1: asynchronous, active-low reset.
REQ-004 Port start, input, 1: request a divide; sampled only when busy=0.
REQ-005 Port dividend, input, WIDTH: numerator; sampled with start.
REQ-006 Port divisor, input, WIDTH: denominator; sampled with start.
REQ-007 Port div_type, input, 2: 00 DIV (signed quotient), 01 DIVU (unsigned quotient), 10 REM (signed remainder), 11 REMU (unsigned remainder); sampled with start.
REQ-008 Port result, output, WIDTH: selected quotient or remainder.
REQ-009 Port busy, output, 1: operation in flight; new start ignored.
REQ-010 Port done, output, 1: single-cycle pulse marking result valid.

Function
REQ-011 Block SHALL be a radix-2 restoring iterative divider with states IDLE, BUSY, FIX and DONE.
REQ-012 IDLE or DONE with start=1 at an edge SHALL do all of the following:
- latch the operands, div_type, and the sign of each signed operand;
- convert signed operands to magnitudes;
- clear the partial remainder;
- load the bit counter with WIDTH;
- enter BUSY.
REQ-013 BUSY SHALL, on each edge:
- shift the partial remainder left by one, bringing in the next dividend MSB;
- subtract the divisor magnitude if the result is non-negative, setting the quotient bit to 1, else set it to 0;
- decrement the counter.
After WIDTH edges the state SHALL go to FIX.
REQ-014 FIX SHALL apply signs, then enter DONE with done=1 for exactly one cycle:
- quotient is negated when the operand signs differ (DIV only);
- remainder takes the dividend's sign (REM only).
REQ-015 Latency: done SHALL be high in the cycle following edge k+WIDTH+1 when start was sampled at edge k, i.e. 65 edges for WIDTH=64.
REQ-016 DONE SHALL return to IDLE on the next edge unless start=1, in which case the new operation is accepted; this gives a back-to-back throughput of one divide per WIDTH+2 cycles.
REQ-017 result SHALL hold its value from done until the next FIX or special-case completion.
REQ-018 busy SHALL be 1 in BUSY and FIX, and 0 otherwise.
REQ-019 start while busy=1 SHALL be ignored, with no effect on the operation in flight.
REQ-020 Divide by zero (all div_types) SHALL return:
- quotient all-ones;
- remainder equal to the original dividend.
REQ-021 Signed overflow (dividend = 1 followed by zeros, divisor = all-ones, DIV/REM only) SHALL return:
- quotient equal to the dividend;
- remainder 0.
REQ-022 Unsigned division SHALL never negate; signs are ignored for DIVU/REMU.

Reset
REQ-023 reset low SHALL immediately force all of the following, regardless of clock:
- state IDLE;
- busy=0, done=0;
- result=0;
- counter=0.
REQ-024 Reset asserted mid-operation SHALL abandon the operation; no done pulse SHALL follow reset release until a new start.
REQ-025 The first start SHALL be accepted at the first edge after reset deasserts.

Configuration
REQ-026 Macro DIV_EARLY_OUT_EN SHALL control special-case completion.
- When defined: divide-by-zero, signed overflow, and dividend magnitude < divisor magnitude SHALL skip BUSY and FIX, going directly to DONE with the REQ-020/021 value. For the magnitude case the quotient is 0 and the remainder is the dividend. done SHALL be high in the cycle after the start edge, and busy SHALL stay 0.
- When undefined: every operation SHALL take the full REQ-015 latency, and special cases SHALL produce identical values after WIDTH+1 edges.

Verification
REQ-027 DIV, dividend -7, divisor 2 -> result 0xFFFFFFFFFFFFFFFD, done at edge 65; REM with the same operands -> 0xFFFFFFFFFFFFFFFF.
REQ-028 DIVU 100/7 -> 14; REMU 100/7 -> 2; busy high for 65 cycles, done pulse 1 cycle wide.
REQ-029 DIV 5/0 -> 0xFFFFFFFFFFFFFFFF; REM 5/0 -> 5; DIV 0x8000000000000000 / 0xFFFFFFFFFFFFFFFF -> 0x8000000000000000; REM with the same operands -> 0. With DIV_EARLY_OUT_EN defined, each of these SHALL complete one cycle after start.
REQ-030 Start DIVU 100/7, pulse start with 9/3 at edge 10 -> second start ignored, result 14; then start 9/3 in the DONE cycle -> accepted, result 3.
REQ-031 Start DIV, assert reset at cycle 30 for 2 cycles -> busy=0, done=0 and result=0 asynchronously; no done pulse follows; a subsequent DIVU 6/3 -> 2.
